thermo_spi_reader: RTL and testbench
====================================

Name: thermo_spi_reader

Overview:
Upstream sensor stage for the hotplate PID loop. It periodically reads a MAX6675-style SPI thermocouple converter (16-bit read-only frame) and converts the 12-bit quarter-degree reading to a signed 16-bit temperature. Its `current_temp` output drives the PID controller's `current_temp` input directly. It also flags open-thermocouple and malformed frames so that higher-level logic can cut heater power.

Parameters:
- CLK_DIV, 4: SCK half-period in clk cycles; legal range ≥2.
- CONV_WAIT, 1000: clk cycles spent with CS high before each frame, giving the sensor its conversion time; legal range ≥1.
- FRAC_SHIFT, 2: right shift applied to the 12-bit reading. The default 2 yields whole degrees C; 0 keeps quarter-degree units.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  when high, the block reads continuously.
- spi_miso  in  1  sensor serial data.
- spi_sck  out  1  serial clock; idles low.
- spi_cs_n  out  1  chip select, active low.
- current_temp  out  16 (signed)  latest good temperature.
- temp_valid  out  1  one-cycle pulse when current_temp updates.
- sensor_fault  out  1  open thermocouple or bad frame detected on the last read.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values (asynchronous, take effect immediately, including mid-frame):
  - spi_cs_n=1, spi_sck=0, current_temp=0, temp_valid=0, sensor_fault=0, busy=0.
  - FSM=IDLE, all counters and the shift register at 0.
- FSM states: IDLE, WAIT, CS_SETUP, SHIFT, CS_HOLD, UPDATE.
- IDLE: spi_cs_n=1. Moves to WAIT on a clock edge with enable=1.
- WAIT: spi_cs_n=1 for CONV_WAIT cycles, then CS_SETUP.
- CS_SETUP: spi_cs_n=0, spi_sck=0 for CLK_DIV cycles, then SHIFT.
- SHIFT:
  - spi_sck toggles every CLK_DIV cycles, starting low.
  - Exactly 16 rising edges, 32*CLK_DIV cycles in total; the state ends with spi_sck low.
  - spi_miso is sampled into the shift register MSB-first on the clk cycle where spi_sck goes 0→1. The sensor changes data on falling edges, so data is stable at that point.
  - spi_miso has no synchronizer; CLK_DIV≥2 guarantees setup.
- CS_HOLD: spi_cs_n=1, spi_sck=0 for CLK_DIV cycles, then UPDATE.
- UPDATE: one cycle. Outputs register at the end of this cycle:
  - Frame fields: bit15 must be 0 (dummy); bits14:3 are the reading; bit2 is the open-thermocouple flag; bits1:0 are ignored.
  - Bad frame (bit2=1 or bit15=1): sensor_fault←1; current_temp is held; temp_valid stays 0.
  - Good frame: current_temp←zero-extend(frame[14:3])>>>FRAC_SHIFT (always non-negative, max 4095>>FRAC_SHIFT); sensor_fault←0; temp_valid=1 for exactly one cycle.
  - Next state is WAIT if enable=1, otherwise IDLE.
- Enable deasserted mid-frame: the current frame always completes and its UPDATE happens. enable is only examined in IDLE and UPDATE.
- Frame period: CONV_WAIT + 34*CLK_DIV + 1 cycles, measured UPDATE-to-UPDATE and from the IDLE→WAIT edge to the first temp_valid.
- SCK counting: the bit counter is 5 bits; the half-period counter has width $clog2(CLK_DIV)+1. Neither wraps inside a frame.
- busy: high in every state except IDLE.

Decomposition:
- Package thermo_pkg holds:
  - state encoding enum;
  - FRAME_BITS=16;
  - field constants: TEMP_MSB=14, TEMP_LSB=3, OPEN_BIT=2, DUMMY_BIT=15.
- One natural sub-module: thermo_sck_div. It is the half-period counter that emits a rise-strobe and a fall-strobe while enabled, and resets to sck=0. All state, shift and decode logic stay in the top module.

Test Plan (bench uses a sensor model driving frames; CLK_DIV=2, CONV_WAIT=10, FRAC_SHIFT=2):
1. Reset: assert reset in the middle of SHIFT → spi_cs_n=1 and spi_sck=0 with no clock edge needed; current_temp=0, sensor_fault=0, busy=0; after release the block sits in IDLE.
2. Good read: enable=1, frame 0x0C80 → exactly 16 SCK rises inside a single CS-low window; temp_valid pulses once, 79 cycles after the enabling edge; current_temp=100.
3. Fault, then recovery: frame 0x0004 after the 0x0C80 read → sensor_fault=1, current_temp stays 100, no temp_valid; next frame 0x7FF8 → sensor_fault=0, current_temp=1023, temp_valid pulses.
4. Bad dummy bit: frame 0x8C80 → sensor_fault=1 and current_temp held.
5. Enable dropped mid-SHIFT → the frame completes, temp_valid pulses, then spi_cs_n stays 1 and busy=0 with no further SCK activity.
6. Continuous run: enable held high for 3 frames → temp_valid pulses spaced exactly 79 cycles apart; CS is high for ≥CONV_WAIT+CLK_DIV cycles between frames.

Source files
------------

// File: rtl/thermo_pkg.sv
// Shared definitions for the thermocouple SPI reader: FSM states and the
// MAX6675-style frame layout.
package thermo_pkg;

  // Frame is 16 bits, read MSB first.
  localparam int FRAME_BITS = 16;

  // Frame field positions.
  localparam int DUMMY_BIT = 15;
  localparam int TEMP_MSB  = 14;
  localparam int TEMP_LSB  = 3;
  localparam int OPEN_BIT  = 2;
  localparam int TEMP_BITS = TEMP_MSB - TEMP_LSB + 1;

  // Width of the temperature result.
  localparam int TEMP_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CS_SETUP,
    S_SHIFT,
    S_CS_HOLD,
    S_UPDATE
  } state_t;

  // A frame is unusable when the open-thermocouple flag is set or the
  // leading dummy bit is not zero (e.g. a floating MISO line).
  function automatic logic frame_bad(input logic [FRAME_BITS-1:0] frame);
    return frame[DUMMY_BIT] | frame[OPEN_BIT];
  endfunction

  // Zero-extend the 12-bit reading and drop FRAC_SHIFT fraction bits.
  function automatic logic [TEMP_W-1:0] frame_temp(
    input logic [FRAME_BITS-1:0] frame,
    input int                    frac_shift
  );
    logic [TEMP_W-1:0] raw;
    raw = {{(TEMP_W - TEMP_BITS){1'b0}}, frame[TEMP_MSB:TEMP_LSB]};
    return raw >> frac_shift;
  endfunction

endpackage

// File: rtl/thermo_spi_reader_if.sv
// SPI bus between the reader (master) and the thermocouple converter (slave).
interface thermo_spi_reader_if;
  logic spi_sck;
  logic spi_cs_n;
  logic spi_miso;

  modport master (
    output spi_sck,
    output spi_cs_n,
    input  spi_miso
  );

  modport slave (
    input  spi_sck,
    input  spi_cs_n,
    output spi_miso
  );
endinterface

// File: rtl/thermo_sck_div.sv
// SCK half-period divider. While enabled, sck toggles every CLK_DIV cycles
// starting from low; rise/fall strobe in the cycle whose closing edge makes
// sck go 0->1 / 1->0. Disabled, it holds sck low and the counter cleared.
module thermo_sck_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(CLK_DIV) + 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] half_cnt_reg;
  logic             at_last;

  assign at_last = en && (half_cnt_reg == HALF_LAST);
  assign rise    = at_last && !sck;
  assign fall    = at_last && sck;

  // Count out each half period and toggle sck at its end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      half_cnt_reg <= '0;
      sck          <= 1'b0;
    end else if (!en) begin
      half_cnt_reg <= '0;
      sck          <= 1'b0;
    end else if (half_cnt_reg == HALF_LAST) begin
      half_cnt_reg <= '0;
      sck          <= ~sck;
    end else begin
      half_cnt_reg <= half_cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/thermo_spi_reader.sv
// Periodic MAX6675-style thermocouple reader. Waits out the conversion time
// with CS high, clocks in one 16-bit frame, then publishes the temperature
// or raises sensor_fault for open-thermocouple / malformed frames.
module thermo_spi_reader
  import thermo_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int CONV_WAIT  = 1000,
  parameter int FRAC_SHIFT = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  thermo_spi_reader_if.master      spi,
  output logic signed [TEMP_W-1:0] current_temp,
  output logic                     temp_valid,
  output logic                     sensor_fault,
  output logic                     busy
);

  // One phase counter serves WAIT, CS_SETUP and CS_HOLD, so size it for
  // the longest of those phases.
  localparam int PH_MAX = (CONV_WAIT > CLK_DIV) ? CONV_WAIT : CLK_DIV;
  localparam int PH_W   = $clog2(PH_MAX) + 1;
  localparam logic [PH_W-1:0] WAIT_LAST = PH_W'(CONV_WAIT - 1);
  localparam logic [PH_W-1:0] DIV_LAST  = PH_W'(CLK_DIV - 1);
  localparam logic [4:0]      BIT_LAST  = 5'(FRAME_BITS);

  state_t                  state_reg;
  logic [PH_W-1:0]         phase_cnt_reg;
  logic [4:0]              bit_cnt_reg;
  logic [FRAME_BITS-1:0]   shift_reg;
  logic                    cs_n_reg;

  logic                    sck;
  logic                    sck_rise;
  logic                    sck_fall;
  logic                    div_en;
  logic                    frame_is_bad;
  logic [TEMP_W-1:0]       frame_temp_val;

  assign div_en = (state_reg == S_SHIFT);

  thermo_sck_div #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_div (
    .clk   (clk),
    .reset (reset),
    .en    (div_en),
    .sck   (sck),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  assign spi.spi_sck  = sck;
  assign spi.spi_cs_n = cs_n_reg;

  // Decode of the captured frame, consumed only in UPDATE.
  assign frame_is_bad   = frame_bad(shift_reg);
  assign frame_temp_val = frame_temp(shift_reg, FRAC_SHIFT);

  // Frame sequencer with registered bus and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      phase_cnt_reg <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      cs_n_reg      <= 1'b1;
      current_temp  <= '0;
      temp_valid    <= 1'b0;
      sensor_fault  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      temp_valid <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          cs_n_reg <= 1'b1;
          if (enable) begin
            state_reg     <= S_WAIT;
            phase_cnt_reg <= '0;
            busy          <= 1'b1;
          end
        end

        // Conversion time: CS stays high so the sensor can convert.
        S_WAIT: begin
          if (phase_cnt_reg == WAIT_LAST) begin
            phase_cnt_reg <= '0;
            cs_n_reg      <= 1'b0;
            state_reg     <= S_CS_SETUP;
          end else begin
            phase_cnt_reg <= phase_cnt_reg + 1'b1;
          end
        end

        // CS low with SCK low for one half period before the first edge;
        // the sensor presents the dummy bit here.
        S_CS_SETUP: begin
          if (phase_cnt_reg == DIV_LAST) begin
            phase_cnt_reg <= '0;
            bit_cnt_reg   <= '0;
            state_reg     <= S_SHIFT;
          end else begin
            phase_cnt_reg <= phase_cnt_reg + 1'b1;
          end
        end

        // Sample MISO on each SCK rise; leave after the 16th falling edge
        // so SCK is low again when CS rises.
        S_SHIFT: begin
          if (sck_rise) begin
            shift_reg   <= {shift_reg[FRAME_BITS-2:0], spi.spi_miso};
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end
          if (sck_fall && (bit_cnt_reg == BIT_LAST)) begin
            cs_n_reg      <= 1'b1;
            phase_cnt_reg <= '0;
            state_reg     <= S_CS_HOLD;
          end
        end

        S_CS_HOLD: begin
          if (phase_cnt_reg == DIV_LAST) begin
            phase_cnt_reg <= '0;
            state_reg     <= S_UPDATE;
          end else begin
            phase_cnt_reg <= phase_cnt_reg + 1'b1;
          end
        end

        // Publish the result; enable decides whether another frame follows.
        S_UPDATE: begin
          if (frame_is_bad) begin
            sensor_fault <= 1'b1;
          end else begin
            current_temp <= $signed(frame_temp_val);
            sensor_fault <= 1'b0;
            temp_valid   <= 1'b1;
          end
          phase_cnt_reg <= '0;
          if (enable) begin
            state_reg <= S_WAIT;
          end else begin
            state_reg <= S_IDLE;
            busy      <= 1'b0;
          end
        end

        default: begin
          state_reg <= S_IDLE;
          cs_n_reg  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_thermo_spi_reader.sv
// Bench for thermo_spi_reader with a behavioural MAX6675 sensor model.
module tb_thermo_spi_reader;

  localparam int CLK_DIV    = 2;
  localparam int CONV_WAIT  = 10;
  localparam int FRAC_SHIFT = 2;
  localparam int PERIOD     = CONV_WAIT + 34 * CLK_DIV + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic signed [15:0] current_temp;
  logic        temp_valid;
  logic        sensor_fault;
  logic        busy;

  thermo_spi_reader_if spi_bus ();

  thermo_spi_reader #(
    .CLK_DIV    (CLK_DIV),
    .CONV_WAIT  (CONV_WAIT),
    .FRAC_SHIFT (FRAC_SHIFT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .spi          (spi_bus),
    .current_temp (current_temp),
    .temp_valid   (temp_valid),
    .sensor_fault (sensor_fault),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- sensor model ----------------
  logic [15:0] next_frame = 16'h0000;
  logic [15:0] sens_sr    = 16'h0000;
  logic        prev_cs    = 1'b1;
  logic        prev_sck   = 1'b0;

  // Load a frame on CS fall, present MSB; advance on each SCK fall.
  always @(spi_bus.spi_cs_n or spi_bus.spi_sck) begin
    if (prev_cs && !spi_bus.spi_cs_n) begin
      sens_sr          = next_frame;
      spi_bus.spi_miso = sens_sr[15];
    end else if (prev_sck && !spi_bus.spi_sck && !spi_bus.spi_cs_n) begin
      sens_sr          = {sens_sr[14:0], 1'b0};
      spi_bus.spi_miso = sens_sr[15];
    end
    prev_cs  = spi_bus.spi_cs_n;
    prev_sck = spi_bus.spi_sck;
  end

  // Bus monitor: cumulative counters, read as differences by the tests.
  int rise_in  = 0;
  int rise_out = 0;
  int cs_falls = 0;
  always @(posedge spi_bus.spi_sck) begin
    if (!spi_bus.spi_cs_n) rise_in++;
    else rise_out++;
  end
  always @(negedge spi_bus.spi_cs_n) cs_falls++;

  // ---------------- reference model ----------------
  int m_temp  = 0;
  int m_fault = 0;

  function automatic int ref_bad(input logic [15:0] f);
    return (f[15] || f[2]) ? 1 : 0;
  endfunction

  function automatic int ref_temp(input logic [15:0] f);
    int reading;
    reading = (int'(f) / 8) % 4096;
    return reading / (1 << FRAC_SHIFT);
  endfunction

  function automatic void model_apply(input logic [15:0] f);
    if (ref_bad(f) != 0) begin
      m_fault = 1;
    end else begin
      m_temp  = ref_temp(f);
      m_fault = 0;
    end
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One enabled frame starting from IDLE; enable dropped after 'hold' cycles.
  task automatic run_frame(
    input  logic [15:0] frame,
    input  int          hold,
    output int          vcount,
    output int          lat,
    output int          r_in,
    output int          r_out,
    output int          falls,
    output int          ended
  );
    int n;
    int rin0, rout0, cf0;
    next_frame = frame;
    rin0  = rise_in;
    rout0 = rise_out;
    cf0   = cs_falls;
    enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n = 0;
    if (hold == 0) enable = 1'b0;
    vcount = 0;
    lat    = -1;
    ended  = 0;
    while (n < 300) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (n == hold) enable = 1'b0;
      if (temp_valid) begin
        vcount++;
        if (lat < 0) lat = n;
      end
      if (!busy) begin
        ended = 1;
        break;
      end
    end
    enable = 1'b0;
    r_in  = rise_in - rin0;
    r_out = rise_out - rout0;
    falls = cs_falls - cf0;
  endtask

  // Checks every observable of one frame against the given expectations.
  task automatic check_frame(
    input logic [15:0] frame,
    input int          hold,
    input int          exp_valid,
    input int          exp_temp,
    input int          exp_fault
  );
    int vcount, lat, r_in, r_out, falls, ended;
    run_frame(frame, hold, vcount, lat, r_in, r_out, falls, ended);
    $display("frame %04h hold=%0d: valid=%0d lat=%0d temp=%0d fault=%0d rises=%0d",
             frame, hold, vcount, lat, current_temp, sensor_fault, r_in);
    check("frame_end", ended, 1);
    check("valid_pulses", vcount, exp_valid);
    if (exp_valid != 0) check("latency", lat, PERIOD);
    check("temp", int'(current_temp), exp_temp);
    check("fault", int'(sensor_fault), exp_fault);
    check("sck_rises_in_cs", r_in, 16);
    check("sck_rises_out_cs", r_out, 0);
    check("cs_windows", falls, 1);
  endtask

  typedef struct {
    logic [15:0] frame;
    int          exp_valid;
    int          exp_temp;
    int          exp_fault;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [15:0] f;
    logic [15:0] cf[3];
    int tv[3];
    int pulses, run, min_gap, n, seen_low, rin0, cs_low_seen;

    vecs[0] = '{16'h0C80, 1, 100,  0};
    vecs[1] = '{16'h0004, 0, 100,  1};
    vecs[2] = '{16'h7FF8, 1, 1023, 0};
    vecs[3] = '{16'h8C80, 0, 1023, 1};
    vecs[4] = '{16'h0000, 1, 0,    0};
    vecs[5] = '{16'h3E83, 1, 500,  0};

    // Reset values.
    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs_n", int'(spi_bus.spi_cs_n), 1);
    check("rst_sck", int'(spi_bus.spi_sck), 0);
    check("rst_temp", int'(current_temp), 0);
    check("rst_valid", int'(temp_valid), 0);
    check("rst_fault", int'(sensor_fault), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b0;
    @(negedge clk);

    // Table-driven single frames.
    for (int i = 0; i < 6; i++) begin
      check_frame(vecs[i].frame, 0, vecs[i].exp_valid, vecs[i].exp_temp, vecs[i].exp_fault);
      model_apply(vecs[i].frame);
    end

    // Enable dropped mid-SHIFT: frame still completes, then everything idles.
    check_frame(16'h0C80, 30, 1, 100, 0);
    model_apply(16'h0C80);
    rin0 = rise_in + rise_out;
    cs_low_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!spi_bus.spi_cs_n || busy) cs_low_seen++;
    end
    check("idle_after_drop", cs_low_seen, 0);
    check("idle_sck_rises", rise_in + rise_out - rin0, 0);

    // Randomized frames against the reference model.
    for (int i = 0; i < 16; i++) begin
      f = 16'($urandom);
      f[15] = ($urandom_range(0, 4) == 0);
      f[2]  = ($urandom_range(0, 3) == 0);
      model_apply(f);
      check_frame(f, $urandom_range(0, 40), (ref_bad(f) != 0) ? 0 : 1, m_temp, m_fault);
    end

    // Continuous run of three good frames; enable drops after the second.
    for (int k = 0; k < 3; k++) begin
      cf[k] = {1'b0, 12'($urandom_range(4, 4095)), 3'b000};
      tv[k] = 0;
    end
    pulses = 0;
    run = 0;
    min_gap = 1000;
    seen_low = 0;
    next_frame = cf[0];
    enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n = 0;
    while (n < 600 && !(pulses >= 3 && !busy)) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (spi_bus.spi_cs_n) begin
        run++;
      end else begin
        if (seen_low != 0 && run > 0 && run < min_gap) min_gap = run;
        seen_low = 1;
        run = 0;
      end
      if (temp_valid) begin
        if (pulses < 3) begin
          tv[pulses] = n;
          model_apply(cf[pulses]);
          $display("cont frame %0d %04h: t=%0d temp=%0d", pulses, cf[pulses], n, current_temp);
          check("cont_temp", int'(current_temp), m_temp);
        end
        pulses++;
        if (pulses < 3) next_frame = cf[pulses];
        if (pulses == 2) enable = 1'b0;
      end
    end
    enable = 1'b0;
    check("cont_pulses", pulses, 3);
    check("cont_idle", int'(busy), 0);
    check("cont_first", tv[0], PERIOD);
    check("cont_spacing1", tv[1] - tv[0], PERIOD);
    check("cont_spacing2", tv[2] - tv[1], PERIOD);
    check("cont_cs_gap_ok", (min_gap >= CONV_WAIT + CLK_DIV && min_gap < 1000) ? 1 : 0, 1);

    // Asynchronous reset in the middle of SHIFT.
    next_frame = 16'h7FF8;
    enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    rin0 = rise_in;
    n = 0;
    while (n < 200 && (rise_in - rin0) < 4) begin
      @(negedge clk);
      n++;
    end
    check("mid_shift_reached", (rise_in - rin0 >= 4) ? 1 : 0, 1);
    check("mid_shift_busy", int'(busy), 1);
    check("mid_shift_cs_low", int'(spi_bus.spi_cs_n), 0);
    #1 reset = 1'b1;
    #1;
    $display("async reset: cs_n=%0d sck=%0d temp=%0d busy=%0d",
             spi_bus.spi_cs_n, spi_bus.spi_sck, current_temp, busy);
    check("areset_cs_n", int'(spi_bus.spi_cs_n), 1);
    check("areset_sck", int'(spi_bus.spi_sck), 0);
    check("areset_temp", int'(current_temp), 0);
    check("areset_fault", int'(sensor_fault), 0);
    check("areset_busy", int'(busy), 0);
    m_temp = 0;
    m_fault = 0;
    @(negedge clk);
    reset = 1'b0;
    cs_low_seen = 0;
    rin0 = rise_in + rise_out;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!spi_bus.spi_cs_n || busy) cs_low_seen++;
    end
    check("post_reset_idle", cs_low_seen, 0);
    check("post_reset_sck", rise_in + rise_out - rin0, 0);

    // A clean frame after reset.
    check_frame(16'h0C80, 0, 1, 100, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
